// File: rtl/matrix_alu_param.sv
// matrix_alu_param
//   Parametrised matrix ALU. Reads operand matrices from a combinational-read
//   slot memory, computes ADD/SUB/MUL/SCA/TRA/HAD and writes the result
//   elements plus result dimensions to a selectable destination slot.
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   start, opcode               request (sampled in IDLE) and operation
//   src_a, src_b, dst           operand slots and result slot
//   scalar_val, sat_en          SCA scalar; clamp (1) or wrap (0) results
//   busy, done, error           handshake: busy window, success pulse, held error
//   err_code, ovf               01 dim mismatch, 10 illegal/zero dim, 11 alias; sticky overflow
//   mem_rd_*                    combinational read address, read data and slot dims
//   mem_wr_*                    registered element write port (one strobe per element)
//   mem_res_m/n, mem_dim_we     registered result dims with one-cycle strobe
module matrix_alu_param #(
    parameter int DW     = 16,
    parameter int DIM_W  = 3,
    parameter int SLOT_W = 2,
    parameter int ACC_W  = 2*DW + DIM_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [2:0]        opcode,
    input  logic [SLOT_W-1:0] src_a,
    input  logic [SLOT_W-1:0] src_b,
    input  logic [SLOT_W-1:0] dst,
    input  logic [DW-1:0]     scalar_val,
    input  logic              sat_en,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [1:0]        err_code,
    output logic              ovf,
    output logic [SLOT_W-1:0] mem_rd_slot,
    output logic [DIM_W-1:0]  mem_rd_row,
    output logic [DIM_W-1:0]  mem_rd_col,
    input  logic [DW-1:0]     mem_rd_data,
    input  logic [DIM_W-1:0]  mem_cur_m,
    input  logic [DIM_W-1:0]  mem_cur_n,
    output logic [SLOT_W-1:0] mem_wr_slot,
    output logic [DIM_W-1:0]  mem_wr_row,
    output logic [DIM_W-1:0]  mem_wr_col,
    output logic [DW-1:0]     mem_wr_data,
    output logic              mem_wr_we,
    output logic [DIM_W-1:0]  mem_res_m,
    output logic [DIM_W-1:0]  mem_res_n,
    output logic              mem_dim_we
);

    typedef enum logic [3:0] {
        S_IDLE, S_DIM_A, S_DIM_B, S_CHECK, S_INIT,
        S_RD_A, S_RD_B, S_MAC, S_WRITE, S_DONE, S_ERROR
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0, OP_SUB = 3'd1, OP_MUL = 3'd2,
        OP_SCA = 3'd3, OP_TRA = 3'd4, OP_HAD = 3'd5
    } op_t;

    localparam logic signed [ACC_W-1:0] MAXV = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV = {{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}};
    localparam logic [DIM_W-1:0]        ONE  = DIM_W'(1);

    state_t                   state;
    logic [2:0]               op_q;
    logic [SLOT_W-1:0]        src_a_q, src_b_q, dst_q;
    logic [DW-1:0]            scal_q;
    logic                     sat_q;
    logic [DIM_W-1:0]         ma, na, mb, nb;
    logic [DIM_W-1:0]         i, j, k;
    logic signed [ACC_W-1:0]  a_q, acc;

    logic signed [ACC_W-1:0]  rd_ext, scal_ext;
    logic                     uses_b, elem_op;
    logic [DIM_W-1:0]         rm, rn;
    logic [1:0]               chk_code;
    logic                     ovf_now;
    logic [DW-1:0]            res_data;

    assign rd_ext      = {{(ACC_W-DW){mem_rd_data[DW-1]}}, mem_rd_data};
    assign scal_ext    = {{(ACC_W-DW){scal_q[DW-1]}}, scal_q};
    assign mem_wr_slot = dst_q;

    assign elem_op = (op_q == OP_ADD) || (op_q == OP_SUB) || (op_q == OP_HAD);
    assign uses_b  = elem_op || (op_q == OP_MUL);

    always_comb begin
        rm = ma;
        rn = na;
        if (op_q == OP_MUL) begin
            rn = nb;
        end else if (op_q == OP_TRA) begin
            rm = na;
            rn = ma;
        end
    end

    // Error classes are checked in priority order; the first hit wins.
    always_comb begin
        chk_code = 2'b00;
        if (op_q > OP_HAD || ma == '0 || na == '0 || (uses_b && (mb == '0 || nb == '0)))
            chk_code = 2'b10;
        else if ((elem_op && (ma != mb || na != nb)) || (op_q == OP_MUL && na != mb))
            chk_code = 2'b01;
        else if (dst_q == src_a_q || (uses_b && dst_q == src_b_q))
            chk_code = 2'b11;
    end

    always_comb begin
        ovf_now  = (acc > MAXV) || (acc < MINV);
        res_data = acc[DW-1:0];
        if (ovf_now && sat_q)
            res_data = (acc > MAXV) ? MAXV[DW-1:0] : MINV[DW-1:0];
    end

    always_comb begin
        mem_rd_slot = '0;
        mem_rd_row  = '0;
        mem_rd_col  = '0;
        case (state)
            S_DIM_A: mem_rd_slot = src_a_q;
            S_DIM_B: mem_rd_slot = src_b_q;
            S_RD_A: begin
                mem_rd_slot = src_a_q;
                if (op_q == OP_TRA) begin
                    mem_rd_row = j;
                    mem_rd_col = i;
                end else if (op_q == OP_MUL) begin
                    mem_rd_row = i;
                    mem_rd_col = k;
                end else begin
                    mem_rd_row = i;
                    mem_rd_col = j;
                end
            end
            S_RD_B: begin
                mem_rd_slot = src_b_q;
                mem_rd_row  = i;
                mem_rd_col  = j;
            end
            S_MAC: begin
                mem_rd_slot = src_b_q;
                mem_rd_row  = k;
                mem_rd_col  = j;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            op_q        <= '0;
            src_a_q     <= '0;
            src_b_q     <= '0;
            dst_q       <= '0;
            scal_q      <= '0;
            sat_q       <= 1'b0;
            ma          <= '0;
            na          <= '0;
            mb          <= '0;
            nb          <= '0;
            i           <= '0;
            j           <= '0;
            k           <= '0;
            a_q         <= '0;
            acc         <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
            err_code    <= '0;
            ovf         <= 1'b0;
            mem_wr_row  <= '0;
            mem_wr_col  <= '0;
            mem_wr_data <= '0;
            mem_wr_we   <= 1'b0;
            mem_res_m   <= '0;
            mem_res_n   <= '0;
            mem_dim_we  <= 1'b0;
        end else begin
            done       <= 1'b0;
            mem_wr_we  <= 1'b0;
            mem_dim_we <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_q     <= opcode;
                        src_a_q  <= src_a;
                        src_b_q  <= src_b;
                        dst_q    <= dst;
                        scal_q   <= scalar_val;
                        sat_q    <= sat_en;
                        error    <= 1'b0;
                        err_code <= '0;
                        ovf      <= 1'b0;
                        busy     <= 1'b1;
                        state    <= S_DIM_A;
                    end
                end
                S_DIM_A: begin
                    ma    <= mem_cur_m;
                    na    <= mem_cur_n;
                    state <= S_DIM_B;
                end
                S_DIM_B: begin
                    mb    <= mem_cur_m;
                    nb    <= mem_cur_n;
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    if (chk_code != 2'b00) begin
                        error    <= 1'b1;
                        err_code <= chk_code;
                        state    <= S_ERROR;
                    end else begin
                        state <= S_INIT;
                    end
                end
                S_INIT: begin
                    mem_res_m  <= rm;
                    mem_res_n  <= rn;
                    mem_dim_we <= 1'b1;
                    i          <= '0;
                    j          <= '0;
                    k          <= '0;
                    acc        <= '0;
                    state      <= S_RD_A;
                end
                S_RD_A: begin
                    case (op_q)
                        OP_MUL: begin
                            a_q   <= rd_ext;
                            state <= S_MAC;
                        end
                        OP_SCA: begin
                            acc   <= rd_ext * scal_ext;
                            state <= S_WRITE;
                        end
                        OP_TRA: begin
                            acc   <= rd_ext;
                            state <= S_WRITE;
                        end
                        default: begin
                            a_q   <= rd_ext;
                            state <= S_RD_B;
                        end
                    endcase
                end
                S_RD_B: begin
                    case (op_q)
                        OP_SUB:  acc <= a_q - rd_ext;
                        OP_HAD:  acc <= a_q * rd_ext;
                        default: acc <= a_q + rd_ext;
                    endcase
                    state <= S_WRITE;
                end
                S_MAC: begin
                    acc <= acc + a_q * rd_ext;
                    if (k == na - ONE) begin
                        k     <= '0;
                        state <= S_WRITE;
                    end else begin
                        k     <= k + ONE;
                        state <= S_RD_A;
                    end
                end
                S_WRITE: begin
                    mem_wr_row  <= i;
                    mem_wr_col  <= j;
                    mem_wr_data <= res_data;
                    mem_wr_we   <= 1'b1;
                    ovf         <= ovf | ovf_now;
                    acc         <= '0;
                    state       <= S_RD_A;
                    if (j == rn - ONE) begin
                        j <= '0;
                        if (i == rm - ONE) begin
                            i     <= '0;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            i <= i + ONE;
                        end
                    end else begin
                        j <= j + ONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                S_ERROR: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
